// File: rtl/knn_pkg.sv
// Shared constants and types for the dist_sort request issuer.
package knn_pkg;

  localparam int unsigned DIM     = 16;
  localparam int unsigned ELEM_W  = 4;
  localparam int unsigned VEC_W   = DIM * ELEM_W;
  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {LOAD, DRAIN, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr_1st;
    logic [ADDR_W-1:0] addr_2nd;
    logic              err;
  } resp_t;

endpackage

// File: rtl/knn_frame_buf.sv
// Register file holding query + search vectors of one frame; all slots readable in parallel.
module knn_frame_buf
  import knn_pkg::*;
#(
  parameter int unsigned Slots = NUM_VEC + 1,
  parameter int unsigned Width = VEC_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [CNT_W-1:0]             idx,
  input  logic [Width-1:0]             data,
  output logic [Slots-1:0][Width-1:0]  slots
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else if (we) begin
      slots[idx] <= data;
    end
  end

endmodule

// File: rtl/knn_req_issuer.sv
// Assembles a 9-word frame, issues one request to dist_sort and returns its result or an error.
module knn_req_issuer
  import knn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [VEC_W-1:0]  s_data,
  input  logic              s_last,
  output logic [VEC_W-1:0]  query,
  output logic [VEC_W-1:0]  search_0,
  output logic [VEC_W-1:0]  search_1,
  output logic [VEC_W-1:0]  search_2,
  output logic [VEC_W-1:0]  search_3,
  output logic [VEC_W-1:0]  search_4,
  output logic [VEC_W-1:0]  search_5,
  output logic [VEC_W-1:0]  search_6,
  output logic [VEC_W-1:0]  search_7,
  output logic              in_valid,
  input  logic [ADDR_W-1:0] addr_1st,
  input  logic [ADDR_W-1:0] addr_2nd,
  input  logic              out_valid,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ADDR_W-1:0] r_addr_1st,
  output logic [ADDR_W-1:0] r_addr_2nd,
  output logic              r_err
);

  localparam resp_t RespErr = '{addr_1st: '0, addr_2nd: '0, err: 1'b1};

  state_e                          state_q;
  logic   [CNT_W-1:0]              cnt_q;
  logic   [TMR_W-1:0]              timer_q;
  resp_t                           resp_q;
  logic   [NUM_VEC:0][VEC_W-1:0]   slots;
  logic                            hs;
  logic                            buf_we;

  assign hs     = s_valid & s_ready;
  assign buf_we = hs & (state_q == LOAD);

  knn_frame_buf u_frame_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .idx   (cnt_q),
    .data  (s_data),
    .slots (slots)
  );

  assign query    = slots[0];
  assign search_0 = slots[1];
  assign search_1 = slots[2];
  assign search_2 = slots[3];
  assign search_3 = slots[4];
  assign search_4 = slots[5];
  assign search_5 = slots[6];
  assign search_6 = slots[7];
  assign search_7 = slots[8];

  assign r_addr_1st = resp_q.addr_1st;
  assign r_addr_2nd = resp_q.addr_2nd;
  assign r_err      = resp_q.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      timer_q  <= '0;
      resp_q   <= '0;
      s_ready  <= 1'b0;
      in_valid <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          s_ready <= 1'b1;
          if (hs) begin
            if (s_last) begin
              s_ready <= 1'b0;
              if (cnt_q == CNT_W'(NUM_VEC)) begin
                state_q  <= ISSUE;
                in_valid <= 1'b1;
              end else begin
                state_q <= RESP;
                r_valid <= 1'b1;
                resp_q  <= RespErr;
              end
            end else if (cnt_q == CNT_W'(NUM_VEC)) begin
              // Frame overran its last slot: swallow words until the sender ends it.
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (hs && s_last) begin
            s_ready <= 1'b0;
            state_q <= RESP;
            r_valid <= 1'b1;
            resp_q  <= RespErr;
          end
        end
        ISSUE: begin
          in_valid <= 1'b0;
          timer_q  <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (out_valid) begin
            resp_q  <= '{addr_1st: addr_1st, addr_2nd: addr_2nd, err: 1'b0};
            r_valid <= 1'b1;
            state_q <= RESP;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            // Last permitted WAIT cycle passed without a result.
            resp_q  <= RespErr;
            r_valid <= 1'b1;
            state_q <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            cnt_q   <= '0;
            s_ready <= 1'b1;
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule
